// File: rtl/stage_id_pkg.sv
// Shared decode definitions for the ID stage: opcodes, functs, ALU op encodings, control word.
package stage_id_pkg;

   localparam int unsigned CTRL_W = 12;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   typedef enum logic [3:0] {
      ALU_NONE = 4'd0,
      ALU_ADD  = 4'd1,
      ALU_SUB  = 4'd2,
      ALU_AND  = 4'd3,
      ALU_OR   = 4'd4,
      ALU_SLT  = 4'd5,
      ALU_SLL  = 4'd6,
      ALU_SRL  = 4'd7
   } alu_op_t;

   // Field order is the ID/EX control word layout, MSB first.
   typedef struct packed {
      logic    is_jump;
      logic    branch_eq;
      logic    branch_ne;
      logic    reg_write;
      logic    mem_read;
      logic    mem_write;
      logic    alu_src;
      logic    reg_dst;
      alu_op_t alu_op;
   } ctrl_t;

   function automatic ctrl_t decode(input logic [31:0] instr);
      ctrl_t c;
      c = '0;
      case (instr[31:26])
         OP_RTYPE: begin
            case (instr[5:0])
               FN_ADD:  c.alu_op = ALU_ADD;
               FN_SUB:  c.alu_op = ALU_SUB;
               FN_AND:  c.alu_op = ALU_AND;
               FN_OR:   c.alu_op = ALU_OR;
               FN_SLT:  c.alu_op = ALU_SLT;
               FN_SLL:  c.alu_op = ALU_SLL;
               FN_SRL:  c.alu_op = ALU_SRL;
               default: c.alu_op = ALU_NONE;
            endcase
            // Unknown funct leaves the whole word zero, same as an unknown opcode.
            c.reg_write = (c.alu_op != ALU_NONE);
            c.reg_dst   = (c.alu_op != ALU_NONE);
         end
         OP_ADDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_ANDI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_AND; end
         OP_ORI:  begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_OR;  end
         OP_SLTI: begin c.reg_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_SLT; end
         OP_LW: begin
            c.reg_write = 1'b1; c.mem_read = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD;
         end
         OP_SW:   begin c.mem_write = 1'b1; c.alu_src = 1'b1; c.alu_op = ALU_ADD; end
         OP_BEQ:  begin c.branch_eq = 1'b1; c.alu_op = ALU_SUB; end
         OP_BNE:  begin c.branch_ne = 1'b1; c.alu_op = ALU_SUB; end
         OP_J:    c.is_jump = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   function automatic logic uses_rt(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
   endfunction

endpackage

// File: rtl/stage_id_reg_file.sv
// Register file: 2 combinational reads, 1 posedge write, r0 hardwired to zero.
// ID_WB_BYPASS_EN: a same-cycle write to the read register is forwarded to the read port.
module stage_id_reg_file #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned COUNT  = 32
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] regs [COUNT];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < COUNT; i++) regs[i] <= '0;
      end else if (wr_en && wr_addr != '0) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
      rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef ID_WB_BYPASS_EN
      if (wr_en && wr_addr != '0 && wr_addr == rd_addr_a) rd_data_a = wr_data;
      if (wr_en && wr_addr != '0 && wr_addr == rd_addr_b) rd_data_b = wr_data;
`endif
   end

endmodule

// File: rtl/stage_id.sv
// MIPS instruction-decode stage: register read, control decode, load-use hazard, ID/EX register.
// Define ID_WB_BYPASS_EN to forward same-cycle write-back data into the register reads.
module stage_id
   import stage_id_pkg::*;
#(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned REG_COUNT  = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_W-1:0]     instruction,
   input  logic [DATA_W-1:0]     iadd,
   input  logic                  nop_in,
   input  logic                  flush,
   input  logic                  ex_mem_read,
   input  logic [REG_ADDR_W-1:0] ex_rt,
   input  logic                  wb_write_en,
   input  logic [REG_ADDR_W-1:0] wb_reg,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  stall,
   output logic [DATA_W-1:0]     id_rs_data,
   output logic [DATA_W-1:0]     id_rt_data,
   output logic [DATA_W-1:0]     id_imm,
   output logic [REG_ADDR_W-1:0] id_rs,
   output logic [REG_ADDR_W-1:0] id_rt,
   output logic [REG_ADDR_W-1:0] id_rd,
   output logic [DATA_W-1:0]     id_npc,
   output logic [DATA_W-1:0]     id_jump_addr,
   output logic [CTRL_W-1:0]     id_ctrl,
   output logic                  id_nop
);

   logic [5:0]            opcode;
   logic [REG_ADDR_W-1:0] rs, rt, rd;
   logic [DATA_W-1:0]     rs_data, rt_data, imm_ext;
   ctrl_t                 ctrl;
   logic                  bubble;

   assign opcode  = instruction[31:26];
   assign rs      = instruction[21 +: REG_ADDR_W];
   assign rt      = instruction[16 +: REG_ADDR_W];
   assign rd      = instruction[11 +: REG_ADDR_W];
   assign imm_ext = {{(DATA_W-16){instruction[15]}}, instruction[15:0]};
   assign ctrl    = decode(instruction);

   stage_id_reg_file #(
      .DATA_W (DATA_W),
      .ADDR_W (REG_ADDR_W),
      .COUNT  (REG_COUNT)
   ) u_reg_file (
      .clock     (clock),
      .reset     (reset),
      .rd_addr_a (rs),
      .rd_addr_b (rt),
      .rd_data_a (rs_data),
      .rd_data_b (rt_data),
      .wr_en     (wb_write_en),
      .wr_addr   (wb_reg),
      .wr_data   (wb_data)
   );

   // The id_nop term ends a stall after one cycle: the bubble it inserts is in EX next cycle.
   assign stall = ex_mem_read & ~id_nop & (ex_rt != '0)
                & ((ex_rt == rs) | ((ex_rt == rt) & uses_rt(opcode)))
                & ~nop_in & ~flush;

   assign bubble = nop_in | flush | stall;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         id_rs_data   <= '0;
         id_rt_data   <= '0;
         id_imm       <= '0;
         id_rs        <= '0;
         id_rt        <= '0;
         id_rd        <= '0;
         id_npc       <= '0;
         id_jump_addr <= '0;
         id_ctrl      <= '0;
         id_nop       <= 1'b1;
      end else begin
         id_rs_data   <= rs_data;
         id_rt_data   <= rt_data;
         id_imm       <= imm_ext;
         id_rs        <= rs;
         id_rt        <= rt;
         id_rd        <= rd;
         id_npc       <= iadd + DATA_W'(1);
         id_jump_addr <= {iadd[DATA_W-1:26], instruction[25:0]};
         id_ctrl      <= '0;
         if (!bubble) id_ctrl <= ctrl;
         id_nop       <= bubble;
      end
   end

endmodule

// File: tb/tb_stage_id.sv
// Self-checking bench for stage_id: directed scenarios plus randomized traffic against a reference model.
module tb_stage_id;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] instruction, iadd, wb_data;
   logic        nop_in, flush, ex_mem_read, wb_write_en;
   logic [4:0]  ex_rt, wb_reg;
   logic        stall;
   logic [31:0] id_rs_data, id_rt_data, id_imm, id_npc, id_jump_addr;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [11:0] id_ctrl;
   logic        id_nop;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_rf [32];
   logic        m_nop;
   logic        e_stall, e_nop;
   logic [11:0] e_ctrl;
   logic [31:0] e_rs_data, e_rt_data, e_imm, e_npc, e_jump;
   logic [4:0]  e_rs, e_rt, e_rd;

   stage_id dut (
      .clock(clock), .reset(reset), .instruction(instruction), .iadd(iadd),
      .nop_in(nop_in), .flush(flush), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
      .wb_write_en(wb_write_en), .wb_reg(wb_reg), .wb_data(wb_data), .stall(stall),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_npc(id_npc),
      .id_jump_addr(id_jump_addr), .id_ctrl(id_ctrl), .id_nop(id_nop)
   );

   always #5 clock = ~clock;

   // {is_jump,beq,bne,reg_write,mem_read,mem_write,alu_src,reg_dst} ++ alu_op (ADD=1..SRL=7)
   function automatic logic [11:0] ref_ctrl(input logic [31:0] ins);
      case (ins[31:26])
         6'h00: case (ins[5:0])
            6'h20: return {8'b0001_0001, 4'd1};
            6'h22: return {8'b0001_0001, 4'd2};
            6'h24: return {8'b0001_0001, 4'd3};
            6'h25: return {8'b0001_0001, 4'd4};
            6'h2A: return {8'b0001_0001, 4'd5};
            6'h00: return {8'b0001_0001, 4'd6};
            6'h02: return {8'b0001_0001, 4'd7};
            default: return 12'h000;
         endcase
         6'h08: return {8'b0001_0010, 4'd1};
         6'h0C: return {8'b0001_0010, 4'd3};
         6'h0D: return {8'b0001_0010, 4'd4};
         6'h0A: return {8'b0001_0010, 4'd5};
         6'h23: return {8'b0001_1010, 4'd1};
         6'h2B: return {8'b0000_0110, 4'd1};
         6'h04: return {8'b0100_0000, 4'd2};
         6'h05: return {8'b0010_0000, 4'd2};
         6'h02: return {8'b1000_0000, 4'd0};
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [31:0] rf_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
`ifdef ID_WB_BYPASS_EN
      if (wb_write_en && wb_reg == idx) return wb_data;
`endif
      return m_rf[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_rf[i] = 32'h0;
      m_nop = 1'b1;
   endtask

   task automatic predict();
      logic [5:0] op;
      logic       rt_read, bub;
      op       = instruction[31:26];
      e_rs     = instruction[25:21];
      e_rt     = instruction[20:16];
      e_rd     = instruction[15:11];
      rt_read  = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h05);
      e_stall  = ex_mem_read && !m_nop && ex_rt != 5'd0 &&
                 (ex_rt == e_rs || (ex_rt == e_rt && rt_read)) && !nop_in && !flush;
      bub      = nop_in || flush || e_stall;
      e_nop    = bub;
      e_ctrl   = bub ? 12'h000 : ref_ctrl(instruction);
      e_rs_data = rf_read(e_rs);
      e_rt_data = rf_read(e_rt);
      e_imm    = 32'($signed(instruction[15:0]));
      e_npc    = iadd + 32'd1;
      e_jump   = (iadd & 32'hFC00_0000) | (instruction & 32'h03FF_FFFF);
   endtask

   task automatic drive(input logic [31:0] ins, input logic [31:0] ad, input logic nop,
                        input logic fl, input logic emr, input logic [4:0] ert,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
      instruction = ins; iadd = ad; nop_in = nop; flush = fl;
      ex_mem_read = emr; ex_rt = ert; wb_write_en = we; wb_reg = wr; wb_data = wd;
      #1;
      predict();
   endtask

   task automatic clock_edge();
      @(posedge clock);
      #1;
      if (wb_write_en && wb_reg != 5'd0) m_rf[wb_reg] = wb_data;
      m_nop = e_nop;
   endtask

   task automatic test_reset();
      drive(32'h0, 32'h0, 1, 0, 0, 0, 1, 5, 32'h5555);
      clock_edge();
      drive(32'h00A5_1820, 32'h8, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if (id_rs_data !== 32'h5555) begin errors++; $display("FAIL pre_reset_r5: got %h expected 00005555", id_rs_data); end
      #2 reset = 1'b1;
      #1;
      checks++; if (id_nop !== 1'b1) begin errors++; $display("FAIL reset_nop: got %b expected 1", id_nop); end
      checks++; if (id_ctrl !== 12'h0) begin errors++; $display("FAIL reset_ctrl: got %h expected 000", id_ctrl); end
      checks++; if ({id_rs_data, id_rt_data, id_npc} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h %h %h expected 0", id_rs_data, id_rt_data, id_npc); end
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
      model_reset();
      @(posedge clock); #1 reset = 1'b0;
      drive(32'h00A5_1820, 32'h8, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if (id_rs_data !== 32'h0 || id_nop !== 1'b0) begin errors++; $display("FAIL reset_rf_cleared: got %h nop %b expected 0 nop 0", id_rs_data, id_nop); end
   endtask

   task automatic test_add();
      drive(32'h0, 32'h0, 1, 0, 0, 0, 1, 5, 32'h1234);
      clock_edge();
      drive(32'h00A5_1820, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if ({id_rs_data, id_rt_data} !== {32'h1234, 32'h1234}) begin errors++; $display("FAIL add_operands: got %h %h expected 00001234 00001234", id_rs_data, id_rt_data); end
      checks++; if (id_npc !== 32'h11) begin errors++; $display("FAIL add_npc: got %h expected 00000011", id_npc); end
      checks++; if (id_ctrl !== 12'h111 || id_rd !== 5'd3) begin errors++; $display("FAIL add_ctrl: got %h rd %0d expected 111 rd 3", id_ctrl, id_rd); end
   endtask

   task automatic test_load_use();
      drive(32'h2001_0001, 32'h20, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      drive(32'h00A0_1820, 32'h21, 0, 0, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_rs: got %b expected 1", stall); end
      clock_edge();
      checks++; if (id_nop !== 1'b1 || id_ctrl !== 12'h0) begin errors++; $display("FAIL lu_bubble: got nop %b ctrl %h expected nop 1 ctrl 000", id_nop, id_ctrl); end
      drive(32'h00A0_1820, 32'h21, 0, 0, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_one_cycle: got %b expected 0", stall); end
      clock_edge();
      checks++; if (id_nop !== 1'b0 || id_ctrl !== 12'h111 || id_npc !== 32'h22) begin errors++; $display("FAIL lu_issue: got nop %b ctrl %h npc %h expected nop 0 ctrl 111 npc 00000022", id_nop, id_ctrl, id_npc); end
      drive(32'h2045_0007, 32'h22, 0, 0, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_rt_unused: got %b expected 0", stall); end
      clock_edge();
      drive(32'h1045_0000, 32'h23, 0, 0, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall_rt_beq: got %b expected 1", stall); end
      clock_edge();
      drive(32'h2001_0001, 32'h24, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      drive(32'h00A0_1820, 32'h25, 0, 0, 1, 0, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_ex_rt_zero: got %b expected 0", stall); end
      clock_edge();
   endtask

   task automatic test_flush();
      drive(32'h2001_0001, 32'h30, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      drive(32'h00A0_1820, 32'h31, 0, 1, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", stall); end
      clock_edge();
      checks++; if (id_nop !== 1'b1 || id_ctrl !== 12'h0) begin errors++; $display("FAIL flush_bubble: got nop %b ctrl %h expected nop 1 ctrl 000", id_nop, id_ctrl); end
      drive(32'h2001_0001, 32'h32, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      drive(32'h00A0_1820, 32'h33, 1, 0, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b0) begin errors++; $display("FAIL nop_in_stall: got %b expected 0", stall); end
      clock_edge();
      checks++; if (id_nop !== 1'b1 || id_ctrl !== 12'h0) begin errors++; $display("FAIL nop_in_bubble: got nop %b ctrl %h expected nop 1 ctrl 000", id_nop, id_ctrl); end
   endtask

   task automatic test_jump_r0();
      drive(32'h0800_0040, 32'h0400_0000, 0, 0, 0, 0, 1, 0, 32'hFFFF);
      clock_edge();
      checks++; if (id_jump_addr !== 32'h0400_0040) begin errors++; $display("FAIL jump_addr: got %h expected 04000040", id_jump_addr); end
      checks++; if (id_ctrl !== 12'h800 || id_nop !== 1'b0) begin errors++; $display("FAIL jump_ctrl: got ctrl %h nop %b expected ctrl 800 nop 0", id_ctrl, id_nop); end
      drive(32'h0000_1820, 32'h40, 0, 0, 0, 0, 1, 0, 32'hFFFF);
      clock_edge();
      checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL r0_same_cycle: got %h expected 0", id_rs_data); end
      drive(32'h0000_1820, 32'h41, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if (id_rs_data !== 32'h0) begin errors++; $display("FAIL r0_after_write: got %h expected 0", id_rs_data); end
   endtask

   task automatic test_bypass();
      logic [31:0] want;
`ifdef ID_WB_BYPASS_EN
      want = 32'hAA;
`else
      want = 32'h0;
`endif
      drive(32'h00E7_1820, 32'h50, 0, 0, 0, 0, 1, 7, 32'hAA);
      clock_edge();
      checks++; if ({id_rs_data, id_rt_data} !== {want, want}) begin errors++; $display("FAIL bypass_same_cycle: got %h %h expected %h", id_rs_data, id_rt_data, want); end
      drive(32'h00E7_1820, 32'h51, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if (id_rs_data !== 32'hAA) begin errors++; $display("FAIL bypass_next_cycle: got %h expected 000000aa", id_rs_data); end
   endtask

   task automatic test_npc_wrap();
      drive(32'h2001_8000, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if (id_npc !== 32'h0) begin errors++; $display("FAIL npc_wrap: got %h expected 00000000", id_npc); end
      checks++; if (id_imm !== 32'hFFFF_8000) begin errors++; $display("FAIL imm_negative: got %h expected ffff8000", id_imm); end
      drive(32'h2001_7FFF, 32'h7FFF_FFFF, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if ({id_npc, id_imm} !== {32'h8000_0000, 32'h0000_7FFF}) begin errors++; $display("FAIL imm_positive: got %h %h expected 80000000 00007fff", id_npc, id_imm); end
   endtask

   task automatic test_reset_mid_stall();
      drive(32'h2001_0001, 32'h60, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      drive(32'h00A0_1820, 32'h61, 0, 0, 1, 5, 0, 0, 0);
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall_pre: got %b expected 1", stall); end
      #2 reset = 1'b1;
      #1;
      checks++; if (stall !== 1'b0 || id_nop !== 1'b1) begin errors++; $display("FAIL rst_stall_drop: got stall %b nop %b expected stall 0 nop 1", stall, id_nop); end
      model_reset();
      @(posedge clock); #1 reset = 1'b0;
      drive(32'h00A5_1820, 32'h62, 0, 0, 0, 0, 0, 0, 0);
      clock_edge();
      checks++; if (id_nop !== 1'b0 || id_rs_data !== 32'h0) begin errors++; $display("FAIL rst_restart: got nop %b rs %h expected nop 0 rs 0", id_nop, id_rs_data); end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  fns [7];
      logic [5:0]  iops [8];
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      int          k;
      fns  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
      iops = '{6'h08, 6'h0C, 6'h0D, 6'h0A, 6'h23, 6'h2B, 6'h04, 6'h05};
      rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
      imm = 16'($urandom);
      k = int'($urandom_range(0, 15));
      if (k < 7) return {6'h00, rs, rt, rd, imm[10:6], fns[k]};
      if (k < 15) return {iops[k-7], rs, rt, imm};
      return imm[0] ? {6'h02, 26'($urandom)} : {6'h3F, 26'($urandom)};
   endfunction

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         drive(rand_instr(), $urandom, ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0),
               1'($urandom), 5'($urandom_range(0, 7)), ($urandom_range(0, 4) < 3),
               5'($urandom_range(0, 7)), $urandom);
         checks++; if (stall !== e_stall) begin errors++; $display("FAIL rand_stall[%0d]: got %b expected %b", n, stall, e_stall); end
         clock_edge();
         checks++; if ({id_ctrl, id_nop} !== {e_ctrl, e_nop}) begin errors++; $display("FAIL rand_ctrl[%0d]: got %h/%b expected %h/%b", n, id_ctrl, id_nop, e_ctrl, e_nop); end
         checks++; if ({id_rs_data, id_rt_data} !== {e_rs_data, e_rt_data}) begin errors++; $display("FAIL rand_operands[%0d]: got %h %h expected %h %h", n, id_rs_data, id_rt_data, e_rs_data, e_rt_data); end
         checks++; if ({id_imm, id_npc, id_jump_addr, id_rs, id_rt, id_rd} !== {e_imm, e_npc, e_jump, e_rs, e_rt, e_rd}) begin
            errors++;
            $display("FAIL rand_fields[%0d]: got %h %h %h %0d %0d %0d expected %h %h %h %0d %0d %0d", n,
                     id_imm, id_npc, id_jump_addr, id_rs, id_rt, id_rd, e_imm, e_npc, e_jump, e_rs, e_rt, e_rd);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      instruction = '0; iadd = '0; nop_in = 1'b0; flush = 1'b0;
      ex_mem_read = 1'b0; ex_rt = '0; wb_write_en = 1'b0; wb_reg = '0; wb_data = '0;
      model_reset();
      repeat (2) @(posedge clock);
      #1 reset = 1'b0;
      test_reset();
      test_add();
      test_load_use();
      test_flush();
      test_jump_r0();
      test_bypass();
      test_npc_wrap();
      test_reset_mid_stall();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
